// File: rtl/exu_mdu.sv
// exu_mdu: iterative RV M-extension multiply/divide unit, one bit per cycle, registered result.
// Define EXU_MDU_FAST_SPECIAL_EN to retire div-by-zero, signed overflow and zero-operand multiplies in one cycle.
module exu_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  src1_i,
  input  logic [XLEN-1:0]  src2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  res_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
`ifdef EXU_MDU_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0] op_q;
  logic [TAG_W-1:0] tag_q;
  logic neg_q, spc_q;
  logic [XLEN-1:0] b_q;
  logic [2*XLEN-1:0] acc_q, acc_nx, sgn_acc;
  logic accept, last, s1, s2, neg1, neg2, z1, z2, ovf, fast;
  logic [XLEN-1:0] abs1, abs2, spc_res, div_v, fin;
  logic [XLEN:0] mul_sum, div_up, div_diff;
  assign in_ready_o = state_q == IDLE || (state_q == DONE && out_ready_i);
  assign out_valid_o = state_q == DONE;
  assign accept = in_valid_i & in_ready_o & ~flush_i;
  assign last = cnt_q == CW'(XLEN - 1);
  always_comb begin
    s1 = op_i[2] ? ~op_i[0] : ~(op_i[1] & op_i[0]);
    s2 = op_i[2] ? ~op_i[0] : ~op_i[1];
    neg1 = s1 & src1_i[XLEN-1];
    neg2 = s2 & src2_i[XLEN-1];
    abs1 = neg1 ? -src1_i : src1_i;
    abs2 = neg2 ? -src2_i : src2_i;
    z1 = src1_i == '0;
    z2 = src2_i == '0;
    ovf = ~op_i[0] & (src1_i == MIN) & (&src2_i);
    fast = FAST & (op_i[2] ? (z2 | ovf) : (z1 | z2));
    spc_res = ~op_i[2] ? '0 : op_i[1] ? (z2 ? src1_i : '0) : (z2 ? '1 : MIN);
  end
  // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_up = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_up - {1'b0, b_q};
    acc_nx = ~op_q[2] ? {mul_sum, acc_q[XLEN-1:1]} :
             div_diff[XLEN] ? {div_up[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                              {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    sgn_acc = neg_q ? -acc_nx : acc_nx;
    div_v = op_q[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    fin = op_q[2] ? (neg_q ? -div_v : div_v) :
          op_q[1:0] == 2'b00 ? sgn_acc[XLEN-1:0] : sgn_acc[2*XLEN-1:XLEN];
  end
  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = IDLE;
    else if (accept) state_d = BUSY;
    else if (state_q == BUSY && last) state_d = DONE;
    else if (state_q == DONE && out_ready_i) state_d = IDLE;
  end
  // special cases park their result at accept and run a single dummy iteration
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      tag_q <= '0;
      neg_q <= 1'b0;
      spc_q <= 1'b0;
      b_q <= '0;
      acc_q <= '0;
      res_o <= '0;
      tag_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= op_i;
        tag_q <= tag_i;
        spc_q <= fast;
        cnt_q <= fast ? CW'(XLEN - 1) : '0;
        neg_q <= op_i[2] ? (op_i[1] ? neg1 : ((neg1 ^ neg2) & ~z2)) : (neg1 ^ neg2);
        b_q <= op_i[2] ? abs2 : abs1;
        acc_q <= {{XLEN{1'b0}}, op_i[2] ? abs1 : abs2};
        if (fast) begin
          res_o <= spc_res;
          tag_o <= tag_i;
        end
      end else if (state_q == BUSY && !flush_i) begin
        acc_q <= acc_nx;
        cnt_q <= cnt_q + CW'(1);
        if (last && !spc_q) begin
          res_o <= fin;
          tag_o <= tag_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_exu_mdu.sv
// tb_exu_mdu: randomized scoreboard bench for exu_mdu (XLEN=32) against an arithmetic reference model.
module tb_exu_mdu;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic in_valid_i = 1'b0, in_ready_o, flush_i = 1'b0, out_valid_o, out_ready_i = 1'b1;
  logic [2:0] op_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0, res_o;
  logic [4:0] tag_i = '0, tag_o;
  int total = 0, bad = 0, cyc = 0;
  bit seen = 1'b0;
  typedef struct {logic [31:0] res; logic [4:0] tag; int acc; int lat;} exp_t;
  exp_t q[$];

  exu_mdu #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i), .tag_i(tag_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .res_o(res_o), .tag_o(tag_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    longint da, db;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    da = longint'($signed(a));
    db = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : 32'(da / db);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : 32'(da % db);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic int lat_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit spc;
    spc = op[2] ? (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF)) : (a == 0 || b == 0);
`ifdef EXU_MDU_FAST_SPECIAL_EN
    return spc ? 1 : 32;
`else
    return spc ? 32 : 32;
`endif
  endfunction

  // monitor: latency on first sight of a result, value/tag on handshake
  always @(negedge clk_i) begin
    if (!rst_n_i) seen = 1'b0;
    else if (out_valid_o) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got res %0h tag %0h expected no output", res_o, tag_o);
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          seen = 1'b1;
        end
        if (out_ready_i) begin
          chk("res", 64'(res_o), 64'(q[0].res));
          chk("tag", 64'(tag_o), 64'(q[0].tag));
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // called just after a posedge; returns just after the accepting posedge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input bit push, input bit rnd);
    int n = 0;
    op_i = op;
    src1_i = a;
    src2_i = b;
    tag_i = tg;
    in_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (in_ready_o) break;
      if (++n > 1000) break;
      @(posedge clk_i);
      #1;
      if (rnd) out_ready_i = $urandom_range(0, 3) != 0;
    end
    if (n > 1000) chk("accept_timeout", 64'(n), 64'd0);
    else if (push) q.push_back('{mdu_ref(op, a, b), tg, cyc + 1, lat_ref(op, a, b)});
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready_i = 1'b1;
    while ((q.size() != 0 || out_valid_o) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit hit;
    int n;
    #12;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_res", 64'(res_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1, 0);
    drain();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1, 0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1, 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1, 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1, 0);
    issue(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 1, 0);
    issue(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8, 1, 0);
    issue(3'd4, 32'd5, 32'd0, 5'd9, 1, 0);
    issue(3'd7, 32'd5, 32'd0, 5'd10, 1, 0);
    issue(3'd4, MIN, 32'hFFFF_FFFF, 5'd11, 1, 0);
    issue(3'd6, MIN, 32'hFFFF_FFFF, 5'd12, 1, 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd13, 1, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd14, 1, 0);
    issue(3'd1, 32'd0, 32'hFFFF_FFF9, 5'd15, 1, 0);
    drain();
    out_ready_i = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd9, 1, 0);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!out_valid_o && n < 100);
    chk("hold_reach_done", 64'(out_valid_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk_i);
      chk("hold_res", 64'(res_o), 64'd14);
      chk("hold_tag", 64'(tag_o), 64'd9);
      chk("hold_in_ready", 64'(in_ready_o), 64'd0);
    end
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    issue(3'd0, 32'd3, 32'd4, 5'd17, 1, 0);
    @(negedge clk_i);
    chk("b2b_out_valid", 64'(out_valid_o), 64'd0);
    chk("b2b_in_ready", 64'(in_ready_o), 64'd0);
    drain();
    issue(3'd5, 32'h1234_5678, 32'd3, 5'd20, 0, 0);
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_idle", 64'(in_ready_o), 64'd1);
    hit = 1'b0;
    repeat (40) begin @(negedge clk_i); hit |= out_valid_o; end
    chk("flush_no_out", 64'(hit), 64'd0);
    @(posedge clk_i);
    #1;
    issue(3'd6, 32'hDEAD_BEEF, 32'd77, 5'd21, 0, 0);
    repeat (5) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_res", 64'(res_o), 64'd0);
    chk("arst_tag", 64'(tag_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    hit = 1'b0;
    repeat (40) begin @(negedge clk_i); hit |= out_valid_o; end
    chk("arst_no_out", 64'(hit), 64'd0);
    @(posedge clk_i);
    #1;
    issue(3'd2, 32'hFFFF_FF00, 32'd300, 5'd22, 1, 0);
    drain();
    for (int i = 0; i < 200; i++)
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 5'($urandom), 1, 1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exu_mdu.md
Name: exu_mdu

Overview:
Iterative multiply/divide execute unit for the RV M-extension. Sits in the E-stage beside the single-cycle ALU/BRU path. Takes one operation per valid/ready handshake from the E-pipe, iterates one bit per cycle, and holds the result in a registered output stage until the M-pipe accepts it. Generalises the E-stage's combinational valid/ready pass-through to a multi-cycle, back-pressurable, flushable unit of parametrised width.

Parameters:
XLEN, 32, operand/result width; legal values are 32 and 64.
TAG_W, 5, width of the opaque tag (rd index) carried alongside the operation.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  operation valid, from E-pipe
in_ready_o  out  1  unit can accept, to E-pipe
op_i  in  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1_i  in  XLEN  rs1 value
src2_i  in  XLEN  rs2 value
tag_i  in  TAG_W  tag, returned unchanged
flush_i  in  1  kill in-flight/held operation
out_valid_o  out  1  result valid, to M-pipe
out_ready_i  in  1  M-pipe accepts result
res_o  out  XLEN  result
tag_o  out  TAG_W  tag of the result

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; out_valid_o=0; res_o=0; tag_o=0; iteration counter=0. Reset mid-operation discards it; no output follows.
- States: IDLE, BUSY, DONE.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i); combinational; always 0 while BUSY.
- Accept = in_valid_i & in_ready_o & ~flush_i. On accept: latch op, tag, absolute-value operands and result-sign flags; counter=0; go to BUSY.
- BUSY: one iteration per cycle. Multiply = radix-2 shift-add on magnitudes into a 2*XLEN product. Divide = restoring shift-subtract on magnitudes. After the iteration with counter==XLEN-1, write res_o/tag_o, including the sign correction, and go to DONE.
- Latency: out_valid_o rises XLEN cycles after the acceptance edge.
- Signedness: MUL and MULH are signed×signed. MULHSU is signed rs1 × unsigned rs2. MULHU is unsigned×unsigned. MUL returns the low XLEN bits of the product; the MULH variants return the high XLEN bits.
- Division sign rules: quotient negated iff the operand signs differ. Remainder takes the dividend's sign.
- Divide by zero: quotient = all ones. Remainder = dividend.
- Signed overflow (DIV/REM of MIN by -1): quotient = MIN. Remainder = 0.
- DONE: out_valid_o=1. res_o and tag_o are held stable until out_ready_i.
  - Handshake with no new accept: go to IDLE.
  - Handshake with a simultaneous accept: go directly to BUSY (back-to-back); out_valid_o drops for the next cycle.
- flush_i: synchronous and highest priority. Next state = IDLE, out_valid_o=0 next cycle, in-flight or held result dropped. An input presented in the same cycle is not accepted.
- in_valid_i while BUSY: ignored (in_ready_o=0). Upstream must hold it.

Optional Feature:
Macro: EXU_MDU_FAST_SPECIAL_EN.
- Defined: divide-by-zero, signed overflow, and any multiply with a zero operand bypass iteration. They go from accept straight to DONE, so out_valid_o rises 1 cycle after acceptance.
- Undefined: these cases iterate the full XLEN cycles.
- Results are identical in both builds; only latency differs.

Test Plan:
1. XLEN=32: MUL 7 × 0xFFFFFFFD, tag 5 -> res 0xFFFFFFEB, tag_o 5, out_valid_o exactly 32 cycles after accept.
2. Operands 0xFFFFFFFF, 0xFFFFFFFF -> MULHU res 0xFFFFFFFE; MULH res 0x00000000; MULHSU res 0xFFFFFFFF.
3. -7 (0xFFFFFFF9) and 2 -> DIV 0xFFFFFFFD; REM 0xFFFFFFFF; DIVU 0x7FFFFFFC; REMU 1.
4. DIV 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Latency is 1 cycle with EXU_MDU_FAST_SPECIAL_EN and 32 without; results match in both builds.
5. Hold out_ready_i=0 for 10 cycles in DONE -> res_o/tag_o stable and in_ready_o=0. Then raise out_ready_i with in_valid_i=1 in the same cycle -> both handshakes occur and the unit enters BUSY.
6. flush_i at BUSY iteration 10 -> IDLE next cycle and no out_valid_o pulse. Deassert rst_n_i mid-BUSY -> outputs 0 immediately (asynchronously). A new op after reset completes normally.
